// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of a single memory slave.
// The core and the UART bridge share the memory. Simultaneous requests alternate
// between the two masters. A stuck slave is covered by a per-transfer timeout.
module wb_mem_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned TIMEOUT        = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  // core port
  input  logic                      i_core_req,
  input  logic                      i_core_we,
  input  logic [31:0]               i_core_adr,
  input  logic [DATA_WIDTH-1:0]     i_core_dat,
  output logic [DATA_WIDTH-1:0]     o_core_dat,
  output logic                      o_core_ack,
  output logic                      o_core_stall,
  // UART bridge Wishbone master
  input  logic                      i_uart_cyc,
  input  logic                      i_uart_stb,
  input  logic                      i_uart_we,
  input  logic [31:0]               i_uart_adr,
  input  logic [DATA_WIDTH-1:0]     i_uart_dat,
  output logic [DATA_WIDTH-1:0]     o_uart_dat,
  output logic                      o_uart_ack,
  // memory slave
  output logic                      o_mem_cyc,
  output logic                      o_mem_stb,
  output logic                      o_mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_adr,
  output logic [DATA_WIDTH-1:0]     o_mem_dat,
  input  logic [DATA_WIDTH-1:0]     i_mem_dat,
  input  logic                      i_mem_ack,
  output logic                      o_timeout
);

  typedef enum logic [1:0] {StIdle, StCore, StUart} state_e;

  // Granted cycle k holds count k-1, so this value marks the TIMEOUT-th cycle.
  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

  state_e      r_state, w_state_next;
  logic        r_last_uart, w_last_uart_next;  // 0: core got the last grant
  logic [7:0]  r_cnt, w_cnt_next;
  logic        w_core_vld, w_uart_vld;

  // Only the low address bits reach memory; the upper bits are ignored on purpose.
  logic w_unused_adr;
  assign w_unused_adr = ^{i_core_adr[31:MEM_ADDR_WIDTH], i_uart_adr[31:MEM_ADDR_WIDTH]};

  assign w_core_vld = i_core_req;
  assign w_uart_vld = i_uart_cyc & i_uart_stb;

  // Arbiter state, last-grant memory and timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_last_uart <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_last_uart <= w_last_uart_next;
      r_cnt       <= w_cnt_next;
    end
  end

  // Next-state decode, bus muxing and completion signalling.
  always_comb begin
    w_state_next     = r_state;
    w_last_uart_next = r_last_uart;
    w_cnt_next       = r_cnt;
    o_mem_cyc        = 1'b0;
    o_mem_stb        = 1'b0;
    o_mem_we         = 1'b0;
    o_mem_adr        = '0;
    o_mem_dat        = '0;
    o_core_ack       = 1'b0;
    o_core_dat       = '0;
    o_uart_ack       = 1'b0;
    o_uart_dat       = '0;
    o_timeout        = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_core_vld && (!w_uart_vld || r_last_uart)) begin
          w_state_next     = StCore;
          w_last_uart_next = 1'b0;
          w_cnt_next       = 8'd0;
        end else if (w_uart_vld) begin
          w_state_next     = StUart;
          w_last_uart_next = 1'b1;
          w_cnt_next       = 8'd0;
        end
      end

      StCore: begin
        o_mem_cyc = 1'b1;
        o_mem_stb = 1'b1;
        o_mem_we  = i_core_we;
        o_mem_adr = i_core_adr[MEM_ADDR_WIDTH-1:0];
        o_mem_dat = i_core_dat;
        // A withdrawn request aborts silently, even over a pending ack or timeout.
        if (!i_core_req) begin
          w_state_next = StIdle;
        end else if (i_mem_ack) begin
          o_core_ack   = 1'b1;
          o_core_dat   = i_mem_dat;
          w_state_next = StIdle;
        end else if (r_cnt == LP_TMO_LAST) begin
          o_core_ack   = 1'b1;
          o_timeout    = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end

      StUart: begin
        o_mem_cyc = 1'b1;
        o_mem_stb = 1'b1;
        o_mem_we  = i_uart_we;
        o_mem_adr = i_uart_adr[MEM_ADDR_WIDTH-1:0];
        o_mem_dat = i_uart_dat;
        if (!i_uart_cyc) begin
          w_state_next = StIdle;
        end else if (i_mem_ack) begin
          o_uart_ack   = 1'b1;
          o_uart_dat   = i_mem_dat;
          w_state_next = StIdle;
        end else if (r_cnt == LP_TMO_LAST) begin
          o_uart_ack   = 1'b1;
          o_timeout    = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end

      default: w_state_next = StIdle;
    endcase
  end

  assign o_core_stall = i_core_req & ~o_core_ack;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: vector table plus hand-written arbitration, abort and
// reset sequences; expected completions are queued and matched against acks.
module tb_wb_mem_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_core_req, i_core_we;
  logic [31:0]   i_core_adr;
  logic [DW-1:0] i_core_dat, o_core_dat;
  logic          o_core_ack, o_core_stall;
  logic          i_uart_cyc, i_uart_stb, i_uart_we;
  logic [31:0]   i_uart_adr;
  logic [DW-1:0] i_uart_dat, o_uart_dat;
  logic          o_uart_ack;
  logic          o_mem_cyc, o_mem_stb, o_mem_we;
  logic [AW-1:0] o_mem_adr;
  logic [DW-1:0] o_mem_dat, i_mem_dat;
  logic          i_mem_ack, o_timeout;

  wb_mem_arbiter #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_core_req(i_core_req), .i_core_we(i_core_we), .i_core_adr(i_core_adr),
    .i_core_dat(i_core_dat), .o_core_dat(o_core_dat), .o_core_ack(o_core_ack),
    .o_core_stall(o_core_stall),
    .i_uart_cyc(i_uart_cyc), .i_uart_stb(i_uart_stb), .i_uart_we(i_uart_we),
    .i_uart_adr(i_uart_adr), .i_uart_dat(i_uart_dat), .o_uart_dat(o_uart_dat),
    .o_uart_ack(o_uart_ack),
    .o_mem_cyc(o_mem_cyc), .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we),
    .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat), .i_mem_dat(i_mem_dat),
    .i_mem_ack(i_mem_ack), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          uart;
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          lat;    // stb cycle on which the slave acks, 0 = never
    logic [31:0] rdat;
    logic [31:0] exp_dat;
    bit          exp_tmo;
    logic [31:0] exp_adr;
    int          exp_gcyc;
  } vec_t;

  typedef struct {
    bit          uart;
    logic [31:0] dat;
    bit          tmo;
    logic [31:0] adr;
    bit          we;
    logic [31:0] wdat;
    int          gcyc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[7];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          core_left, uart_left, g_lat;
  logic [31:0] g_rdat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Drives both masters and the slave until every pending transfer has completed.
  task automatic run(input int budget);
    int   stb_cnt = 0;
    int   cyc     = 0;
    bit   prev_ack = 0;
    exp_t e;
    while ((core_left > 0 || uart_left > 0) && cyc < budget) begin
      @(negedge clk);
      i_core_req = (core_left > 0);
      i_uart_cyc = (uart_left > 0);
      i_uart_stb = (uart_left > 0);
      if (o_mem_stb) stb_cnt++;
      else stb_cnt = 0;
      i_mem_ack = o_mem_stb && g_lat != 0 && stb_cnt == g_lat;
      i_mem_dat = g_rdat;
      #1;
      if (prev_ack) chk("idle_after_ack", {31'd0, o_mem_cyc}, 0);
      chk("core_stall", {31'd0, o_core_stall}, {31'd0, i_core_req & ~o_core_ack});
      prev_ack = 0;
      if (o_core_ack || o_uart_ack) begin
        prev_ack = 1;
        if (sb.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("ack_master", {31'd0, o_uart_ack}, {31'd0, e.uart});
          chk("other_ack_zero", {31'd0, e.uart ? o_core_ack : o_uart_ack}, 0);
          chk("other_dat_zero", e.uart ? o_core_dat : o_uart_dat, 0);
          chk("rd_dat", e.uart ? o_uart_dat : o_core_dat, e.dat);
          chk("timeout_flag", {31'd0, o_timeout}, {31'd0, e.tmo});
          chk("mem_adr", {22'd0, o_mem_adr}, e.adr);
          chk("mem_we", {31'd0, o_mem_we}, {31'd0, e.we});
          chk("mem_dat", o_mem_dat, e.wdat);
          chk("grant_cycle", stb_cnt, e.gcyc);
        end
        if (o_uart_ack) uart_left--;
        else core_left--;
      end else begin
        chk("stray_timeout", {31'd0, o_timeout}, 0);
      end
      cyc++;
    end
    @(negedge clk);
    i_core_req = 0; i_uart_cyc = 0; i_uart_stb = 0; i_mem_ack = 0;
    #1;
    if (prev_ack) chk("idle_after_ack", {31'd0, o_mem_cyc}, 0);
    chk("all_done", sb.size(), 0);
    sb.delete();
    core_left = 0; uart_left = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  // Waits (bounded) until the arbiter drives the memory bus.
  task automatic wait_grant(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!o_mem_cyc && k < 5);
    chk(nm, {31'd0, o_mem_cyc}, 1);
  endtask

  initial begin
    rst = 1;
    i_core_req = 0; i_core_we = 0; i_core_adr = 0; i_core_dat = 0;
    i_uart_cyc = 0; i_uart_stb = 0; i_uart_we = 0; i_uart_adr = 0; i_uart_dat = 0;
    i_mem_dat = 0; i_mem_ack = 0;
    core_left = 0; uart_left = 0; g_lat = 2; g_rdat = 0;

    // uart, we, adr, wdat, lat, rdat, exp_dat, exp_tmo, exp_adr (low AW bits), exp_gcyc
    vecs[0] = '{0, 0, 32'h0000_0104, 32'h0000_0000, 2,  32'h1234_5678, 32'h1234_5678, 0, 32'h104, 2};
    vecs[1] = '{1, 1, 32'h0000_03FF, 32'hAAAA_5555, 1,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 32'h3FF, 1};
    vecs[2] = '{0, 1, 32'hFFFF_F800, 32'h0F0F_F0F0, 3,  32'h0000_0001, 32'h0000_0001, 0, 32'h000, 3};
    vecs[3] = '{1, 1, 32'h0000_0200, 32'h5A5A_A5A5, 0,  32'hCAFE_F00D, 32'h0000_0000, 1, 32'h200, 15};
    vecs[4] = '{0, 0, 32'h0000_0155, 32'h0000_0000, 15, 32'h7777_8888, 32'h7777_8888, 0, 32'h155, 15};
    vecs[5] = '{0, 0, 32'h0000_02AA, 32'h0000_0000, 16, 32'h9999_1111, 32'h0000_0000, 1, 32'h2AA, 15};
    vecs[6] = '{1, 0, 32'h8000_0033, 32'h0000_0000, 14, 32'h1357_9BDF, 32'h1357_9BDF, 0, 32'h033, 14};

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_cyc", {31'd0, o_mem_cyc}, 0);
    chk("rst_mem_stb", {31'd0, o_mem_stb}, 0);
    chk("rst_mem_we", {31'd0, o_mem_we}, 0);
    chk("rst_core_ack", {31'd0, o_core_ack}, 0);
    chk("rst_uart_ack", {31'd0, o_uart_ack}, 0);
    chk("rst_timeout", {31'd0, o_timeout}, 0);
    @(negedge clk);
    rst = 0;

    // Single-master transfers; the idle master carries decoy values.
    for (int i = 0; i < 7; i++) begin
      i_core_we  = vecs[i].uart ? ~vecs[i].we : vecs[i].we;
      i_core_adr = vecs[i].uart ? ~vecs[i].adr : vecs[i].adr;
      i_core_dat = vecs[i].uart ? ~vecs[i].wdat : vecs[i].wdat;
      i_uart_we  = vecs[i].uart ? vecs[i].we : ~vecs[i].we;
      i_uart_adr = vecs[i].uart ? vecs[i].adr : ~vecs[i].adr;
      i_uart_dat = vecs[i].uart ? vecs[i].wdat : ~vecs[i].wdat;
      g_lat  = vecs[i].lat;
      g_rdat = vecs[i].rdat;
      sb.push_back('{vecs[i].uart, vecs[i].exp_dat, vecs[i].exp_tmo, vecs[i].exp_adr,
                     vecs[i].we, vecs[i].wdat, vecs[i].exp_gcyc});
      if (vecs[i].uart) uart_left = 1;
      else core_left = 1;
      run(40);
    end

    // Both request together after reset: UART first, then strict alternation.
    do_reset();
    i_core_we = 0; i_core_adr = 32'h0000_0010; i_core_dat = 32'h0000_0011;
    i_uart_we = 0; i_uart_adr = 32'h0000_0020; i_uart_dat = 32'h0000_0022;
    g_lat = 2; g_rdat = 32'h5555_0000;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) sb.push_back('{1, 32'h5555_0000, 0, 32'h020, 0, 32'h22, 2});
      else sb.push_back('{0, 32'h5555_0000, 0, 32'h010, 0, 32'h11, 2});
    end
    core_left = 3; uart_left = 3;
    run(100);

    // Core withdraws its request mid-transfer: no ack, no timeout, bus released.
    i_core_adr = 32'h0000_00AB;
    i_core_req = 1;
    wait_grant("abort_core_grant");
    @(negedge clk);
    i_core_req = 0;
    #1;
    chk("abort_core_ack", {31'd0, o_core_ack}, 0);
    chk("abort_core_tmo", {31'd0, o_timeout}, 0);
    @(negedge clk);
    #1;
    chk("abort_core_idle", {31'd0, o_mem_cyc}, 0);

    // UART drops cyc mid-transfer with stb still high.
    i_uart_cyc = 1; i_uart_stb = 1;
    wait_grant("abort_uart_grant");
    @(negedge clk);
    i_uart_cyc = 0;
    #1;
    chk("abort_uart_ack", {31'd0, o_uart_ack}, 0);
    chk("abort_uart_tmo", {31'd0, o_timeout}, 0);
    @(negedge clk);
    i_uart_stb = 0;
    #1;
    chk("abort_uart_idle", {31'd0, o_mem_cyc}, 0);

    // Slave ack while nobody is granted is ignored.
    i_mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("idle_ack_ignored", {30'd0, o_core_ack, o_uart_ack}, 0);
      chk("idle_no_cyc", {31'd0, o_mem_cyc}, 0);
    end
    i_mem_ack = 0;

    // Reset during a granted core transfer drops the bus at once, then a retry works.
    i_core_adr = 32'h0000_00C0; i_core_dat = 32'h0000_0C0C; i_core_we = 1;
    i_core_req = 1;
    wait_grant("rst_mid_grant");
    #2 rst = 1;
    #1;
    chk("rst_mid_cyc", {31'd0, o_mem_cyc}, 0);
    chk("rst_mid_stb", {31'd0, o_mem_stb}, 0);
    chk("rst_mid_ack", {31'd0, o_core_ack}, 0);
    @(negedge clk);
    rst = 0;
    g_lat = 2; g_rdat = 32'h0BAD_CAFE;
    sb.push_back('{0, 32'h0BAD_CAFE, 0, 32'h0C0, 1, 32'h0000_0C0C, 2});
    core_left = 1;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
